// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program-counter unit.
// Holds the fetch PC and selects the next address from sequential, immediate
// jump, register jump, conditional branch, call and return modes. A stall
// holds all state. A circular return-address stack (RAS) serves call/return,
// and one-cycle redirect / ras_miss pulses accompany the updated PC.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   advance        current instruction valid; PC may update this cycle
//   stall          hold PC and RAS; overrides advance
//   jump[2:0]      000 seq, 001 jimm, 010 jreg, 011 branch, 100 call,
//                  101 return, 110/111 seq
//   instruction    current instruction; [25:0] is the jump index
//   j_reg          register-jump target; return fallback on empty RAS
//   branch_offset  sign-extended word offset
//   branch_result  branch condition true
//   pc             current fetch address (registered)
//   pc_plus        pc + 4 (combinational)
//   redirect       pulse: last update was non-sequential
//   ras_count      valid RAS entries, saturating at RAS_DEPTH
//   ras_miss       pulse: return executed with an empty RAS
module pc_sequencer #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     RESET_PC  = '0,
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           advance,
    input  logic                           stall,
    input  logic [2:0]                     jump,
    input  logic [WIDTH-1:0]               instruction,
    input  logic [WIDTH-1:0]               j_reg,
    input  logic [WIDTH-1:0]               branch_offset,
    input  logic                           branch_result,
    output logic [WIDTH-1:0]               pc,
    output logic [WIDTH-1:0]               pc_plus,
    output logic                           redirect,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_miss
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] J_SEQ    = 3'b000;
    localparam logic [2:0] J_IMM    = 3'b001;
    localparam logic [2:0] J_REG    = 3'b010;
    localparam logic [2:0] J_BRANCH = 3'b011;
    localparam logic [2:0] J_CALL   = 3'b100;
    localparam logic [2:0] J_RETURN = 3'b101;

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_dec;

    logic [WIDTH-1:0] jimm_target;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] next_pc;
    logic             next_redirect;
    logic             next_miss;
    logic             push;
    logic             pop;
    logic             update;

    // Upper instruction bits are not part of the jump index.
    logic             unused_instr;
    assign unused_instr = ^instruction[WIDTH-1:26];

    assign pc_plus       = pc + WIDTH'(4);
    assign jimm_target   = {pc_plus[WIDTH-1:28], instruction[25:0], 2'b00};
    assign branch_target = pc_plus + (branch_offset << 2);
    assign ptr_dec       = ptr - PW'(1);
    assign update        = advance & ~stall;

    always_comb begin
        next_pc       = pc_plus;
        next_redirect = 1'b0;
        next_miss     = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        case (jump)
            J_SEQ: next_pc = pc_plus;
            J_IMM: begin
                next_pc       = jimm_target;
                next_redirect = 1'b1;
            end
            J_REG: begin
                next_pc       = j_reg;
                next_redirect = 1'b1;
            end
            J_BRANCH: begin
                if (branch_result) begin
                    next_pc       = branch_target;
                    next_redirect = 1'b1;
                end
            end
            J_CALL: begin
                next_pc       = jimm_target;
                next_redirect = 1'b1;
                push          = 1'b1;
            end
            J_RETURN: begin
                next_redirect = 1'b1;
                if (ras_count != '0) begin
                    next_pc = ras[ptr_dec];
                    pop     = 1'b1;
                end else begin
                    next_pc   = j_reg;
                    next_miss = 1'b1;
                end
            end
            default: next_pc = pc_plus;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            redirect  <= 1'b0;
            ras_miss  <= 1'b0;
            ras_count <= '0;
            ptr       <= '0;
        end else if (update) begin
            pc       <= next_pc;
            redirect <= next_redirect;
            ras_miss <= next_miss;
            if (push) begin
                // Pointer wraps naturally (power-of-two depth); a push when
                // full overwrites the oldest entry and count stays saturated.
                ptr <= ptr + PW'(1);
                if (ras_count != CW'(RAS_DEPTH))
                    ras_count <= ras_count + CW'(1);
            end else if (pop) begin
                ptr       <= ptr_dec;
                ras_count <= ras_count - CW'(1);
            end
        end else begin
            redirect <= 1'b0;
            ras_miss <= 1'b0;
        end
    end

    // Stack contents need no reset; validity is tracked by ras_count.
    always_ff @(posedge clk) begin
        if (update && push)
            ras[ptr] <= pc_plus;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized self-checking bench for pc_sequencer.
// A behavioural model (PC value plus a bounded queue of return addresses)
// predicts every output each cycle; directed scenarios add constant checks
// on the values the design is expected to produce.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        advance;
    logic        stall;
    logic [2:0]  jump;
    logic [31:0] instruction;
    logic [31:0] j_reg;
    logic [31:0] branch_offset;
    logic        branch_result;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        redirect;
    logic [2:0]  ras_count;
    logic        ras_miss;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_redir;
    bit          m_miss;
    logic [31:0] m_ras[$];
    localparam int DEPTH = 4;

    pc_sequencer #(
        .WIDTH     (32),
        .RESET_PC  (32'h0),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .advance       (advance),
        .stall         (stall),
        .jump          (jump),
        .instruction   (instruction),
        .j_reg         (j_reg),
        .branch_offset (branch_offset),
        .branch_result (branch_result),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .redirect      (redirect),
        .ras_count     (ras_count),
        .ras_miss      (ras_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("pc",        pc,                      m_pc);
        check("pc_plus",   pc_plus,                 m_pc + 32'd4);
        check("redirect",  {31'd0, redirect},       {31'd0, m_redir});
        check("ras_count", {29'd0, ras_count},      32'(m_ras.size()));
        check("ras_miss",  {31'd0, ras_miss},       {31'd0, m_miss});
    endtask

    // Drive one cycle (inputs applied away from the edge), predict, check.
    task automatic do_cycle(input bit adv, input bit stl, input logic [2:0] jmp,
                            input logic [31:0] instr, input logic [31:0] jr,
                            input logic [31:0] off, input bit br);
        logic [31:0] pp;
        logic [31:0] nxt;
        bit          rd;
        bit          ms;
        advance       = adv;
        stall         = stl;
        jump          = jmp;
        instruction   = instr;
        j_reg         = jr;
        branch_offset = off;
        branch_result = br;
        pp  = m_pc + 32'd4;
        nxt = m_pc;
        rd  = 0;
        ms  = 0;
        if (adv && !stl) begin
            nxt = pp;
            case (jmp)
                3'd1: begin nxt = {pp[31:28], instr[25:0], 2'b00}; rd = 1; end
                3'd2: begin nxt = jr; rd = 1; end
                3'd3: if (br) begin nxt = pp + (off * 32'd4); rd = 1; end
                3'd4: begin
                    nxt = {pp[31:28], instr[25:0], 2'b00};
                    rd  = 1;
                    m_ras.push_back(pp);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
                3'd5: begin
                    rd = 1;
                    if (m_ras.size() > 0) nxt = m_ras.pop_back();
                    else begin nxt = jr; ms = 1; end
                end
                default: nxt = pp;
            endcase
        end
        @(posedge clk);
        #1;
        m_pc    = nxt;
        m_redir = rd;
        m_miss  = ms;
        check_model();
    endtask

    task automatic seq_step();
        do_cycle(1, 0, 3'd0, 32'h0, 32'h0, 32'h0, 0);
    endtask

    task automatic set_pc(input logic [31:0] target);
        do_cycle(1, 0, 3'd2, 32'h0, target, 32'h0, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        m_pc    = 32'h0;
        m_redir = 0;
        m_miss  = 0;
        m_ras.delete();
        check_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        advance = 0; stall = 0; jump = 3'd0;
        instruction = '0; j_reg = '0; branch_offset = '0; branch_result = 0;
        m_pc = 0; m_redir = 0; m_miss = 0;
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rst_n = 1'b1;

        // T1: reset mid-run with pc=0x40
        set_pc(32'h40);
        call_and_check_t1();

        // T2: sequential then stall
        seq_step(); check("t2_pc4", pc, 32'h4);
        seq_step(); check("t2_pc8", pc, 32'h8);
        seq_step(); check("t2_pcC", pc, 32'hC);
        repeat (2) begin
            do_cycle(1, 1, 3'd0, 32'h0, 32'h0, 32'h0, 0);
            check("t2_hold", pc, 32'hC);
            check("t2_redir", {31'd0, redirect}, 32'd0);
        end

        // T3: branch taken / not taken, offset -2
        set_pc(32'h100);
        do_cycle(1, 0, 3'd3, 32'h0, 32'h0, 32'hFFFF_FFFE, 1);
        check("t3_taken", pc, 32'hFC);
        check("t3_taken_redir", {31'd0, redirect}, 32'd1);
        set_pc(32'h100);
        do_cycle(1, 0, 3'd3, 32'h0, 32'h0, 32'hFFFF_FFFE, 0);
        check("t3_ntaken", pc, 32'h104);
        check("t3_ntaken_redir", {31'd0, redirect}, 32'd0);

        // T4: immediate and register jumps
        set_pc(32'h1000_0010);
        do_cycle(1, 0, 3'd1, 32'h40, 32'h0, 32'h0, 0);
        check("t4_jimm", pc, 32'h1000_0100);
        check("t4_jimm_redir", {31'd0, redirect}, 32'd1);
        set_pc(32'h2000);
        check("t4_jreg", pc, 32'h2000);

        // T5: call/return/empty return
        set_pc(32'h20);
        do_cycle(1, 0, 3'd4, 32'h100, 32'h0, 32'h0, 0);
        check("t5_call_cnt", {29'd0, ras_count}, 32'd1);
        do_cycle(1, 0, 3'd5, 32'h0, 32'h0, 32'h0, 0);
        check("t5_ret_pc", pc, 32'h24);
        check("t5_ret_cnt", {29'd0, ras_count}, 32'd0);
        do_cycle(1, 0, 3'd5, 32'h0, 32'h80, 32'h0, 0);
        check("t5_miss_pc", pc, 32'h80);
        check("t5_miss", {31'd0, ras_miss}, 32'd1);
        seq_step();
        check("t5_miss_pulse", {31'd0, ras_miss}, 32'd0);

        // T6: overflow with five calls, then five returns
        set_pc(32'h100);
        for (int unsigned i = 1; i <= 5; i++)
            do_cycle(1, 0, 3'd4, 32'(i * 32'h100), 32'h0, 32'h0, 0);
        check("t6_cnt_full", {29'd0, ras_count}, 32'd4);
        do_cycle(1, 0, 3'd5, 32'h0, 32'h0, 32'h0, 0); check("t6_E", pc, 32'h1004);
        do_cycle(1, 0, 3'd5, 32'h0, 32'h0, 32'h0, 0); check("t6_D", pc, 32'hC04);
        do_cycle(1, 0, 3'd5, 32'h0, 32'h0, 32'h0, 0); check("t6_C", pc, 32'h804);
        do_cycle(1, 0, 3'd5, 32'h0, 32'h0, 32'h0, 0); check("t6_B", pc, 32'h404);
        do_cycle(1, 0, 3'd5, 32'h0, 32'h3000, 32'h0, 0);
        check("t6_miss_pc", pc, 32'h3000);
        check("t6_miss", {31'd0, ras_miss}, 32'd1);

        // Randomized traffic, biased towards call/return
        for (int unsigned n = 0; n < 600; n++) begin
            logic [2:0] jm;
            int unsigned r;
            r  = $urandom_range(0, 9);
            jm = (r < 3) ? 3'd4 : (r < 6) ? 3'd5 : 3'($urandom_range(0, 7));
            if (n == 300) apply_reset();
            do_cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, jm,
                     $urandom, $urandom & 32'hFFFF_FFFC,
                     32'($signed($urandom_range(0, 64)) - 32), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic call_and_check_t1();
        check("t1_pre_pc", pc, 32'h40);
        // Push an entry so the reset has RAS state to discard
        do_cycle(1, 0, 3'd4, 32'h10, 32'h0, 32'h0, 0);
        apply_reset();
        check("t1_pc", pc, 32'h0);
        check("t1_redir", {31'd0, redirect}, 32'd0);
        check("t1_cnt", {29'd0, ras_count}, 32'd0);
    endtask

endmodule
